gf180mcu_ocd_io__pwr_seq: RTL

// - Power-up/power-down sequencer for the DVDD/VDD pad ring.
// - Qualifies the analog supply-good flags, debounces them, and releases POR_N.
// - Enables pad driver groups one at a time to limit inrush on DVDD/DVSS.
// - Disables the groups in reverse order on sleep, and all at once on supply loss.
// - Sits in the always-on core domain, beside the dvdd/dvss supply cells.

---
 rtl/gf180mcu_ocd_io__pwr_pkg.sv | 33 +++
 rtl/gf180mcu_ocd_io__sync2.sv | 27 ++
 rtl/gf180mcu_ocd_io__pwr_seq.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/gf180mcu_ocd_io__pwr_pkg.sv
// Shared types and widths for the DVDD/VDD pad-ring power sequencer.
package gf180mcu_ocd_io__pwr_pkg;

  // Sequencer states; the encoding is visible on the STATE debug port.
  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_DEB   = 3'd1,
    ST_UP    = 3'd2,
    ST_ON    = 3'd3,
    ST_DOWN  = 3'd4,
    ST_FAULT = 3'd5
  } pwr_state_e;

  localparam int DEB_CYC_DFLT   = 1024;
  localparam int STAGE_CYC_DFLT = 64;
  localparam int NGRP_DFLT      = 4;

  // Shared step counter must reach the larger of the two terminal counts.
  function automatic int cnt_width(input int deb_cyc, input int stage_cyc);
    int m;
    m = (deb_cyc > stage_cyc) ? deb_cyc : stage_cyc;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

  // Group index carries one spare bit so it can hold NGRP itself.
  function automatic int idx_width(input int ngrp);
    return $clog2(ngrp) + 1;
  endfunction

  localparam int CNT_W = cnt_width(DEB_CYC_DFLT, STAGE_CYC_DFLT);
  localparam int IDX_W = idx_width(NGRP_DFLT);

endpackage

// File: rtl/gf180mcu_ocd_io__sync2.sv
// Two-flop synchronizer, clears to 0 on reset, for the asynchronous supply flags.
module gf180mcu_ocd_io__sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  // NOTE: clocked state uses non-blocking assignments so both flops sample
  // their inputs from before the edge; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/gf180mcu_ocd_io__pwr_seq.sv
// Power-up/power-down sequencer for the DVDD/VDD pad ring: debounces the supply
// flags, releases POR_N, staggers pad group enables and handles supply loss.
module gf180mcu_ocd_io__pwr_seq
  import gf180mcu_ocd_io__pwr_pkg::*;
#(
  parameter int DEB_CYC   = DEB_CYC_DFLT,
  parameter int STAGE_CYC = STAGE_CYC_DFLT,
  parameter int NGRP      = NGRP_DFLT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            DVDD_OK,
  input  logic            VDD_OK,
  input  logic            SLEEP_REQ,
  input  logic            FAULT_CLR,
  output logic [NGRP-1:0] PAD_EN,
  output logic            POR_N,
  output logic            READY,
  output logic            FAULT,
  output logic [2:0]      STATE
);

  localparam int CW = cnt_width(DEB_CYC, STAGE_CYC);
  localparam int IW = idx_width(NGRP);

  logic dvdd_s, vdd_s, sleep_s;
  logic ok, slp;

  gf180mcu_ocd_io__sync2 u_sync_dvdd (.clk(CLK), .rst(RST), .d(DVDD_OK),   .q(dvdd_s));
  gf180mcu_ocd_io__sync2 u_sync_vdd  (.clk(CLK), .rst(RST), .d(VDD_OK),    .q(vdd_s));
  gf180mcu_ocd_io__sync2 u_sync_slp  (.clk(CLK), .rst(RST), .d(SLEEP_REQ), .q(sleep_s));

  assign ok  = dvdd_s & vdd_s;
  assign slp = sleep_s;

  logic [2:0]      state_q,  state_d;
  logic [CW-1:0]   cnt_q,    cnt_d;
  logic [IW-1:0]   idx_q,    idx_d;
  logic [NGRP-1:0] pad_en_q, pad_en_d;
  logic            por_n_q,  por_n_d;
  logic            ready_q,  ready_d;
  logic            fault_q,  fault_d;
  logic [NGRP-1:0] grp_bit;
  logic            stage_done;

  // Next-state, counter and output-register logic for the sequencer.
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    pad_en_d   = pad_en_q;
    por_n_d    = por_n_q;
    ready_d    = ready_q;
    fault_d    = fault_q;
    grp_bit    = NGRP'(1) << idx_q;
    stage_done = (cnt_q == CW'(STAGE_CYC - 1));

    case (state_q)
      ST_OFF: begin
        pad_en_d = '0;
        por_n_d  = 1'b0;
        ready_d  = 1'b0;
        if (ok && !slp) begin
          state_d = ST_DEB;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end

      ST_DEB: begin
        if (!ok) begin
          state_d = ST_OFF;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt_q == CW'(DEB_CYC - 1)) begin
          state_d = ST_UP;
          por_n_d = 1'b1;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_UP: begin
        // Sleep is deliberately not looked at until the ring is fully up.
        if (!ok) begin
          state_d  = ST_FAULT;
          pad_en_d = '0;
          por_n_d  = 1'b0;
          ready_d  = 1'b0;
          fault_d  = 1'b1;
          cnt_d    = '0;
          idx_d    = '0;
        end else if (stage_done) begin
          pad_en_d = pad_en_q | grp_bit;
          cnt_d    = '0;
          if (idx_q == IW'(NGRP - 1)) begin
            state_d = ST_ON;
            ready_d = 1'b1;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_ON: begin
        if (!ok) begin
          state_d  = ST_FAULT;
          pad_en_d = '0;
          por_n_d  = 1'b0;
          ready_d  = 1'b0;
          fault_d  = 1'b1;
          cnt_d    = '0;
          idx_d    = '0;
        end else if (slp) begin
          state_d = ST_DOWN;
          ready_d = 1'b0;
          cnt_d   = '0;
          idx_d   = IW'(NGRP - 1);
        end
      end

      ST_DOWN: begin
        // Once started, power-down always runs to OFF even if sleep drops.
        if (!ok) begin
          state_d  = ST_FAULT;
          pad_en_d = '0;
          por_n_d  = 1'b0;
          ready_d  = 1'b0;
          fault_d  = 1'b1;
          cnt_d    = '0;
          idx_d    = '0;
        end else if (stage_done) begin
          pad_en_d = pad_en_q & ~grp_bit;
          cnt_d    = '0;
          if (idx_q == '0) begin
            state_d = ST_OFF;
            por_n_d = 1'b0;
          end else begin
            idx_d = idx_q - IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_FAULT: begin
        // Sticky until software acknowledges; supply recovery alone is not enough.
        pad_en_d = '0;
        por_n_d  = 1'b0;
        ready_d  = 1'b0;
        if (FAULT_CLR) begin
          state_d = ST_OFF;
          fault_d = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end

      default: begin
        // Unused encodings fall back to a safe, fully disabled OFF.
        state_d  = ST_OFF;
        pad_en_d = '0;
        por_n_d  = 1'b0;
        ready_d  = 1'b0;
        cnt_d    = '0;
        idx_d    = '0;
      end
    endcase
  end

  // State, counters and registered outputs, all cleared by the async reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_OFF;
      cnt_q    <= '0;
      idx_q    <= '0;
      pad_en_q <= '0;
      por_n_q  <= 1'b0;
      ready_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      pad_en_q <= pad_en_d;
      por_n_q  <= por_n_d;
      ready_q  <= ready_d;
      fault_q  <= fault_d;
    end
  end

  assign PAD_EN = pad_en_q;
  assign POR_N  = por_n_q;
  assign READY  = ready_q;
  assign FAULT  = fault_q;
  assign STATE  = state_q;

endmodule
